// File: rtl/result_to_usb_if.sv
// Wishbone read-master and FX2 slave-FIFO write signals of result_to_usb.
// master = result_to_usb side, slave = SDRAM/FX2/controller side.
interface result_to_usb_if;
  logic        stb_i;
  logic        cyc_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        sdram_ack;
  logic        FLAGD;
  logic [1:0]  FIFOADR;
  logic        SLWR;
  logic        PKTEND;
  logic [15:0] fdata_o;
  logic        fdata_oe;

  modport master (
    output stb_i, cyc_i, we_i, sel_i, addr_i, data_i,
    input  data_o, stall_o, sdram_ack,
    input  FLAGD,
    output FIFOADR, SLWR, PKTEND, fdata_o, fdata_oe
  );

  modport slave (
    input  stb_i, cyc_i, we_i, sel_i, addr_i, data_i,
    output data_o, stall_o, sdram_ack,
    output FLAGD,
    input  FIFOADR, SLWR, PKTEND, fdata_o, fdata_oe
  );
endinterface

// File: rtl/result_to_usb.sv
// Reads word_cnt 16-bit results from SDRAM over Wishbone (one read outstanding) and writes
// each to the FX2 IN FIFO, committing a short final packet with PKTEND.
module result_to_usb #(
  parameter int         CNT_W     = 8,
  parameter int         PKT_WORDS = 256,
  parameter logic [1:0] EP_ADR    = 2'b10
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  result_to_usb_if.master  bus
);

  localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [PW-1:0] PKT_LAST = PW'(PKT_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_WAIT, WR_STB, TAIL, FIN
  } state_t;

  state_t           state, state_nxt;
  logic [31:0]      base_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] idx;
  logic [PW-1:0]    pkt_cnt;
  logic [15:0]      fdata_q;
  logic             oe_q;
  logic             rd_done;
  logic [CNT_W:0]   idx_inc;
  logic             more_words;
  logic             pkt_last;
  logic             unused_data_hi;

  // Ack in RD_REQ together with an accepted strobe counts as the read completing.
  assign rd_done    = ((state == RD_REQ) && !bus.stall_o && bus.sdram_ack) ||
                      ((state == RD_WAIT) && bus.sdram_ack);
  assign idx_inc    = {1'b0, idx} + {{CNT_W{1'b0}}, 1'b1};
  assign more_words = idx_inc < {1'b0, cnt_r};
  assign pkt_last   = (pkt_cnt == PKT_LAST);
  assign unused_data_hi = ^bus.data_o[31:16];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_cnt == '0) ? FIN : RD_REQ;
      RD_REQ:  if (!bus.stall_o) state_nxt = bus.sdram_ack ? WR_WAIT : RD_WAIT;
      RD_WAIT: if (bus.sdram_ack) state_nxt = WR_WAIT;
      WR_WAIT: if (bus.FLAGD) state_nxt = WR_STB;
      WR_STB: begin
        if (more_words)    state_nxt = RD_REQ;
        else if (pkt_last) state_nxt = FIN;
        else               state_nxt = TAIL;
      end
      TAIL:    if (bus.FLAGD) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_r  <= '0;
      cnt_r   <= '0;
      idx     <= '0;
      pkt_cnt <= '0;
      fdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_r  <= base_addr;
        cnt_r   <= word_cnt;
        idx     <= '0;
        pkt_cnt <= '0;
      end
      if (rd_done) fdata_q <= bus.data_o[15:0];
      if (state == WR_STB) begin
        idx     <= idx + CNT_W'(1);
        pkt_cnt <= pkt_last ? '0 : pkt_cnt + PW'(1);
      end
      // FDATA stays driven from the first captured word until FIN so it holds across every strobe.
      if (state_nxt == WR_WAIT)                        oe_q <= 1'b1;
      else if (state_nxt == FIN || state_nxt == IDLE) oe_q <= 1'b0;
    end
  end

  assign busy         = (state != IDLE) && (state != FIN);
  assign done         = (state == FIN);
  assign bus.stb_i    = (state == RD_REQ);
  assign bus.cyc_i    = (state == RD_REQ) || (state == RD_WAIT);
  assign bus.we_i     = 1'b0;
  assign bus.sel_i    = bus.cyc_i ? 4'b0011 : 4'b0000;
  assign bus.addr_i   = base_r + 32'(idx);
  assign bus.data_i   = 32'd0;
  assign bus.SLWR     = !(state == WR_STB);
  assign bus.PKTEND   = !((state == TAIL) && bus.FLAGD);
  assign bus.FIFOADR  = busy ? EP_ADR : 2'b00;
  assign bus.fdata_o  = fdata_q;
  assign bus.fdata_oe = oe_q;

endmodule

// File: tb/tb_result_to_usb.sv
// Randomized bench for result_to_usb: SDRAM/FX2 environment plus a transfer-level reference model.
module tb_result_to_usb;
  localparam int CNT_W = 9;
  localparam int PKT   = 256;

  logic             CLK = 1'b0;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_cnt;
  logic             busy;
  logic             done;

  result_to_usb_if bus();

  result_to_usb #(.CNT_W(CNT_W), .PKT_WORDS(PKT), .EP_ADR(2'b10)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .bus(bus)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Environment knobs
  int lat_mode = 0;        // 0: ack +1, 1: ack same cycle, 2: random 0..2
  bit rand_stall = 0, rand_full = 0;
  int stall_word = -1, stall_left = 0;
  int full_word = -1, full_left = 0;

  // Observations
  logic [15:0] wr_q[$];
  logic [31:0] acc_q[$];
  int pktend_n, done_n, stb_n, acks, accepts, done_wr, done_pk;
  int v_hold, v_flag, v_bus, v_wb;
  int pend_cnt;
  logic [31:0] pend_addr, held_addr;
  bit holding;
  logic prev_flagd;
  logic [15:0] prev_fd;
  bit prev_slwr_low;

  // SDRAM contents: odd multiplier keeps neighbouring words distinct.
  function automatic logic [15:0] mkdata(input logic [31:0] a);
    logic [15:0] m;
    m = a[15:0] * 16'd40503;
    return m ^ a[31:16] ^ 16'h3C5A;
  endfunction

  task automatic clear_mon();
    wr_q.delete(); acc_q.delete();
    pktend_n = 0; done_n = 0; stb_n = 0; acks = 0; accepts = 0; done_wr = -1; done_pk = -1;
    v_hold = 0; v_flag = 0; v_bus = 0; v_wb = 0;
  endtask

  initial begin
    int lat;
    logic [31:0] tmp;
    bus.stall_o = 0; bus.sdram_ack = 0; bus.data_o = 0; bus.FLAGD = 1;
    pend_cnt = 0; holding = 0; prev_flagd = 1; prev_fd = 0; prev_slwr_low = 0;
    clear_mon();
    forever begin
      @(negedge CLK);
      if (!rst_n) begin
        pend_cnt = 0; holding = 0; full_left = 0;
        bus.sdram_ack = 0; bus.stall_o = 0; bus.FLAGD = 1;
      end else begin
        tmp = $urandom;
        bus.sdram_ack = 0;
        bus.data_o = tmp;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            bus.sdram_ack = 1; bus.data_o = {tmp[31:16], mkdata(pend_addr)}; acks++;
          end
        end
        bus.stall_o = 0;
        if (bus.stb_i) begin
          if (holding && bus.addr_i !== held_addr) v_wb++;
          if (accepts == stall_word && stall_left > 0) begin
            bus.stall_o = 1; stall_left--; holding = 1; held_addr = bus.addr_i;
          end else if (rand_stall && $urandom_range(3) == 0) begin
            bus.stall_o = 1; holding = 1; held_addr = bus.addr_i;
          end else begin
            holding = 0;
            if (accepts != acks) v_wb++;
            acc_q.push_back(bus.addr_i);
            accepts++;
            lat = (lat_mode == 0) ? 1 : (lat_mode == 1) ? 0 : int'($urandom_range(2));
            if (lat == 0) begin
              bus.sdram_ack = 1; bus.data_o = {tmp[31:16], mkdata(bus.addr_i)}; acks++;
            end else begin
              pend_cnt = lat; pend_addr = bus.addr_i;
            end
          end
        end
        if (full_left > 0) begin
          bus.FLAGD = 0; full_left--;
        end else if (full_word >= 0 && wr_q.size() == full_word) begin
          bus.FLAGD = 0; full_left = 9; full_word = -1;
        end else if (rand_full) bus.FLAGD = ($urandom_range(2) != 0);
        else bus.FLAGD = 1;
      end
      #1;
      if (rst_n) begin
        if (!bus.SLWR) begin
          wr_q.push_back(bus.fdata_o);
          if (prev_flagd !== 1'b1 || bus.fdata_oe !== 1'b1 || bus.fdata_o !== prev_fd) v_hold++;
        end
        if (prev_slwr_low && bus.fdata_o !== prev_fd) v_hold++;
        if (!bus.PKTEND) begin
          pktend_n++;
          if (bus.FLAGD !== 1'b1) v_flag++;
        end
        if (done) begin
          done_n++; done_wr = wr_q.size(); done_pk = pktend_n;
          if (busy) v_bus++;
        end
        if (bus.stb_i) stb_n++;
        if (bus.FIFOADR !== (busy ? 2'b10 : 2'b00) || bus.we_i !== 1'b0 || bus.data_i !== 32'd0 ||
            bus.sel_i !== (bus.cyc_i ? 4'b0011 : 4'b0000)) v_bus++;
        prev_flagd = bus.FLAGD; prev_fd = bus.fdata_o; prev_slwr_low = !bus.SLWR;
      end else prev_slwr_low = 0;
    end
  end

  task automatic do_reset();
    @(negedge CLK); rst_n = 0;
    repeat (2) @(negedge CLK);
    rst_n = 1;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] base, input int cnt, input bit mid_start);
    int bad, exp_pk, budget, c;
    logic [31:0] a;
    clear_mon();
    exp_pk = (cnt != 0 && (cnt % PKT) != 0) ? 1 : 0;
    budget = cnt * 40 + 60;
    @(negedge CLK);
    start = 1; base_addr = base; word_cnt = CNT_W'(cnt);
    @(negedge CLK);
    start = 0; base_addr = $urandom; word_cnt = CNT_W'($urandom);
    #2;
    if (cnt != 0) begin
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start: got %b want 1", tag, busy); end
    end
    for (c = 0; c < budget && done_n == 0; c++) begin
      @(negedge CLK);
      start = (mid_start && c == 5 && done_n == 0);
      base_addr = $urandom; word_cnt = CNT_W'($urandom);
    end
    start = 0;
    checks++;
    if (done_n == 0) begin
      failures++; $display("FAIL %s done_timeout: no done after %0d cycles", tag, budget);
      do_reset();
    end
    repeat (3) @(negedge CLK);
    #2;
    bad = 0;
    if (wr_q.size() != cnt) bad++;
    else for (int i = 0; i < cnt; i++) begin
      a = base + 32'(i);
      if (wr_q[i] !== mkdata(a)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL %s fifo_words: got %0d words (%0d bad) want %0d", tag, wr_q.size(), bad, cnt);
    end
    bad = 0;
    if (acc_q.size() != cnt) bad++;
    else for (int i = 0; i < cnt; i++) if (acc_q[i] !== base + 32'(i)) bad++;
    checks++;
    if (bad != 0 || acks != cnt) begin
      failures++; $display("FAIL %s wb_reads: got %0d reads %0d acks (%0d bad) want %0d", tag, acc_q.size(), acks, bad, cnt);
    end
    checks++;
    if (pktend_n != exp_pk || done_n != 1) begin
      failures++; $display("FAIL %s pktend_done: got pktend=%0d done=%0d want pktend=%0d done=1", tag, pktend_n, done_n, exp_pk);
    end
    checks++;
    if (done_wr != cnt || done_pk != exp_pk) begin
      failures++; $display("FAIL %s done_order: at done writes=%0d pktend=%0d want %0d/%0d", tag, done_wr, done_pk, cnt, exp_pk);
    end
    checks++;
    if (v_hold != 0 || v_flag != 0 || v_bus != 0 || v_wb != 0) begin
      failures++; $display("FAIL %s protocol: hold=%0d flag=%0d bus=%0d wb=%0d want all 0", tag, v_hold, v_flag, v_bus, v_wb);
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs, exp;
    rst_n = 0; start = 0; base_addr = 0; word_cnt = 0;
    #3;
    obs = {busy, done, bus.SLWR, bus.PKTEND, bus.fdata_oe, bus.stb_i, bus.cyc_i, bus.FIFOADR, bus.sel_i};
    exp = 13'b0011000000000;
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_ctrl: got %b want %b", obs, exp); end
    checks++;
    if ({bus.fdata_o, bus.addr_i} !== 48'd0) begin
      failures++; $display("FAIL reset_data: got fdata=%h addr=%h want 0", bus.fdata_o, bus.addr_i);
    end
    repeat (2) @(negedge CLK);
    rst_n = 1;
  endtask

  task automatic test_basic();
    lat_mode = 0; rand_stall = 0; rand_full = 0;
    run_xfer("basic", 32'd18, 3, 0);
  endtask

  task automatic test_full_packet();
    run_xfer("full_packet", 32'h0000_1000, PKT, 0);
  endtask

  task automatic test_fifo_full();
    full_word = 2;
    run_xfer("fifo_full", 32'h0000_0400, 5, 0);
    full_word = -1;
  endtask

  task automatic test_stall();
    stall_word = 0; stall_left = 3;
    run_xfer("stall", 32'h0000_2000, 3, 0);
    checks++;
    if (stb_n != 6) begin failures++; $display("FAIL stall_stb_cycles: got %0d want 6", stb_n); end
    stall_word = -1;
  endtask

  task automatic test_zero_count();
    clear_mon();
    @(negedge CLK);
    start = 1; base_addr = 32'h55; word_cnt = '0;
    @(negedge CLK);
    start = 0;
    #2;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL zero_done: got done=%b busy=%b want 1/0", done, busy);
    end
    repeat (4) @(negedge CLK);
    #2;
    checks++;
    if (done_n != 1 || wr_q.size() != 0 || pktend_n != 0 || stb_n != 0) begin
      failures++; $display("FAIL zero_quiet: got done=%0d slwr=%0d pktend=%0d stb=%0d want 1/0/0/0", done_n, wr_q.size(), pktend_n, stb_n);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs, exp;
    int c;
    clear_mon();
    full_word = 5;
    @(negedge CLK);
    start = 1; base_addr = 32'h0000_3000; word_cnt = CNT_W'(10);
    @(negedge CLK);
    start = 0;
    for (c = 0; c < 2000; c++) begin
      #2;
      if (wr_q.size() == 5 && acks == 6 && !bus.cyc_i && busy && bus.fdata_oe) break;
      @(negedge CLK);
    end
    checks++;
    if (c >= 2000) begin failures++; $display("FAIL midreset_reach: WR_WAIT of word 5 not reached"); end
    rst_n = 0;
    #1;
    obs = {busy, done, bus.SLWR, bus.PKTEND, bus.fdata_oe, bus.stb_i, bus.cyc_i, bus.FIFOADR, bus.sel_i};
    exp = 13'b0011000000000;
    checks++;
    if (obs !== exp || bus.fdata_o !== 16'd0 || bus.addr_i !== 32'd0) begin
      failures++; $display("FAIL midreset_outputs: got %b fdata=%h addr=%h want %b 0 0", obs, bus.fdata_o, bus.addr_i, exp);
    end
    full_word = -1;
    repeat (2) @(negedge CLK);
    rst_n = 1;
    repeat (3) @(negedge CLK);
    #2;
    checks++;
    if (done_n != 0 || wr_q.size() != 5) begin
      failures++; $display("FAIL midreset_abandon: got done=%0d writes=%0d want 0/5", done_n, wr_q.size());
    end
    run_xfer("after_reset", $urandom, 2, 0);
  endtask

  task automatic test_random_back_to_back();
    int cnt;
    logic [31:0] base;
    lat_mode = 2; rand_stall = 1; rand_full = 1;
    for (int t = 0; t < 10; t++) begin
      cnt  = (t == 0) ? 255 : (t == 1) ? 257 : int'($urandom_range(80, 1));
      base = (t == 2) ? 32'hFFFF_FFFE : $urandom;
      run_xfer($sformatf("rand%0d", t), base, cnt, (cnt >= 3) && ($urandom_range(1) == 1));
    end
    lat_mode = 1; rand_stall = 0; rand_full = 0;
    run_xfer("ack_same_cycle", 32'h0000_0010, 4, 0);
    lat_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_packet();
    test_fifo_full();
    test_stall();
    test_zero_count();
    test_reset_mid();
    test_random_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
